// File: rtl/alu_share_arbiter_if.sv
// Bundle of the request, ALU and response channels of alu_share_arbiter.
// The slave modport is the arbiter's view; master is the client/ALU side.
interface alu_share_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 5,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ*2-1:0]     req_sel;
  logic [WIDTH-1:0]         alu_a;
  logic [WIDTH-1:0]         alu_b;
  logic [1:0]               alu_sel;
  logic [WIDTH-1:0]         alu_out;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [WIDTH-1:0]         rsp_data;
  logic [ID_W-1:0]          rsp_id;
  logic                     busy;

  modport master (
    output req_valid, req_a, req_b, req_sel, alu_out, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_data, rsp_id, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sel, alu_out, rsp_ready,
    output req_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_data, rsp_id, busy
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one external combinational ALU between NUM_REQ
// requesters. One op in flight at a time: accept (IDLE), execute (EXEC),
// return the registered result tagged with the requester ID (RESP).
module alu_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 5,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               rst,
  alu_share_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} stateT;

  stateT              state;
  logic [ID_W-1:0]    rrPtr;
  logic [ID_W-1:0]    idQ;
  logic [WIDTH-1:0]   aluA;
  logic [WIDTH-1:0]   aluB;
  logic [1:0]         aluSel;
  logic               rspValid;
  logic [WIDTH-1:0]   rspData;
  logic [ID_W-1:0]    rspId;
  logic               busy;

  logic               anyValid;
  logic [ID_W-1:0]    winner;
  logic [ID_W-1:0]    cand;
  logic [ID_W-1:0]    nextPtr;
  logic [NUM_REQ-1:0] reqReady;
  logic [WIDTH-1:0]   selA;
  logic [WIDTH-1:0]   selB;
  logic [1:0]         selOp;

  // First valid requester at or above rrPtr, wrapping; scanning downward so
  // the nearest candidate is the last one written.
  always_comb begin
    anyValid = 1'b0;
    winner   = rrPtr;
    cand     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ID_W'((int'(rrPtr) + k) % NUM_REQ);
      if (bus.req_valid[cand]) begin
        anyValid = 1'b1;
        winner   = cand;
      end
    end
  end

  assign nextPtr = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);

  // Grant only while idle; depends on state, rrPtr and req_valid alone.
  always_comb begin
    reqReady = '0;
    if (state == IDLE && anyValid) reqReady[winner] = 1'b1;
  end

  // Route the winner's payload with constant slices.
  always_comb begin
    selA  = '0;
    selB  = '0;
    selOp = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        selA  = bus.req_a[i*WIDTH +: WIDTH];
        selB  = bus.req_b[i*WIDTH +: WIDTH];
        selOp = bus.req_sel[i*2 +: 2];
      end
    end
  end

  // Control FSM with registered ALU operands and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rrPtr    <= '0;
      idQ      <= '0;
      aluA     <= '0;
      aluB     <= '0;
      aluSel   <= '0;
      rspValid <= 1'b0;
      rspData  <= '0;
      rspId    <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (anyValid) begin
            aluA   <= selA;
            aluB   <= selB;
            aluSel <= selOp;
            idQ    <= winner;
            rrPtr  <= nextPtr;
            busy   <= 1'b1;
            state  <= EXEC;
          end
        end
        EXEC: begin
          rspData  <= bus.alu_out;
          rspId    <= idQ;
          rspValid <= 1'b1;
          state    <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rspValid <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          rspValid <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = reqReady;
  assign bus.alu_a     = aluA;
  assign bus.alu_b     = aluB;
  assign bus.alu_sel   = aluSel;
  assign bus.rsp_valid = rspValid;
  assign bus.rsp_data  = rspData;
  assign bus.rsp_id    = rspId;
  assign bus.busy      = busy;

endmodule
